// File: rtl/accum_sched_pkg.sv
// Shared definitions for the two-accumulator command scheduler:
// opcode encodings, scheduler state type and the accumulator count.
package accum_sched_pkg;

  localparam int NUM_ACC = 2;

  localparam logic [2:0] OP_INCR  = 3'b001;
  localparam logic [2:0] OP_DECR  = 3'b010;
  localparam logic [2:0] OP_OTHER = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } sched_state_t;

  function automatic logic op_is_halt(input logic [2:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves to one past the winner only when something is granted.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic          found;

  // First pass covers requesters at or above the pointer, second pass wraps.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr_reg)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/accum_cmd_sched.sv
// Command scheduler feeding two accumulators: per-target round-robin
// acceptance, registered issue, and a halt/drain sequence with timeout.
module accum_cmd_sched
  import accum_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DRAIN_TMO = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_vld,
  input  logic [NUM_REQ-1:0]      req_tgt,
  input  logic [NUM_REQ*3-1:0]    req_op,
  output logic [NUM_REQ-1:0]      req_rdy,
  output logic [NUM_ACC-1:0]      cmd_vld,
  output logic [NUM_ACC*3-1:0]    opcode,
  input  logic                    halt,
  output logic                    sched_halted,
  output logic                    drain_err,
  output logic [NUM_ACC*16-1:0]   issue_cnt
);

  localparam int            CW         = $clog2(DRAIN_TMO + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TMO - 1);

  sched_state_t state_reg, state_next;
  logic [CW-1:0] drain_cnt_reg, drain_cnt_next;
  logic          drain_err_reg, drain_err_next;
  logic          drain_timeout;
  logic          run_en;
  logic          halt_accept;

  logic [NUM_ACC-1:0][NUM_REQ-1:0] acc_req;
  logic [NUM_ACC-1:0][NUM_REQ-1:0] acc_gnt;
  logic [NUM_ACC-1:0]              gnt_any;
  logic [NUM_ACC-1:0][2:0]         gnt_op;

  logic [NUM_ACC-1:0]              cmd_vld_reg;
  logic [NUM_ACC-1:0][2:0]         opcode_reg;
  logic [NUM_ACC-1:0][15:0]        issue_cnt_reg;

  // Masking requests here keeps both arbiters idle (pointers frozen) outside RUN.
  assign run_en = (state_reg == ST_RUN) && !reset;

  always_comb begin
    acc_req = '0;
    for (int a = 0; a < NUM_ACC; a++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        acc_req[a][r] = run_en && req_vld[r] && (int'(req_tgt[r]) == a);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_acc
      rr_arb #(
        .N(NUM_REQ)
      ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req  (acc_req[gi]),
        .grant(acc_gnt[gi])
      );
    end
  endgenerate

  always_comb begin
    gnt_any     = '0;
    gnt_op      = '0;
    req_rdy     = '0;
    halt_accept = 1'b0;
    for (int a = 0; a < NUM_ACC; a++) begin
      gnt_any[a] = |acc_gnt[a];
      req_rdy    = req_rdy | acc_gnt[a];
      for (int r = 0; r < NUM_REQ; r++) begin
        if (acc_gnt[a][r]) begin
          gnt_op[a] = req_op[r*3 +: 3];
        end
      end
      if (gnt_any[a] && op_is_halt(gnt_op[a])) begin
        halt_accept = 1'b1;
      end
    end
  end

  // Scheduler FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
      drain_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      drain_err_reg <= drain_err_next;
    end
  end

  // Scheduler FSM: next state; two halts in one cycle still mean one DRAIN entry
  always_comb begin
    state_next    = state_reg;
    drain_timeout = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (halt_accept) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (halt) begin
          state_next = ST_HALTED;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
          state_next    = ST_HALTED;
          drain_timeout = 1'b1;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
    drain_cnt_next = (state_reg == ST_DRAIN) ? drain_cnt_reg + CW'(1) : '0;
    drain_err_next = drain_err_reg | drain_timeout;
  end

  // Scheduler FSM: outputs
  always_comb begin
    sched_halted = (state_reg == ST_HALTED);
    drain_err    = drain_err_reg;
  end

  // Issue stage: opcode holds when nothing is issued to that accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_vld_reg   <= '0;
      opcode_reg    <= '0;
      issue_cnt_reg <= '0;
    end else begin
      for (int a = 0; a < NUM_ACC; a++) begin
        cmd_vld_reg[a] <= gnt_any[a];
        if (gnt_any[a]) begin
          opcode_reg[a]    <= gnt_op[a];
          issue_cnt_reg[a] <= issue_cnt_reg[a] + 16'd1;
        end
      end
    end
  end

  assign cmd_vld   = cmd_vld_reg;
  assign opcode    = opcode_reg;
  assign issue_cnt = issue_cnt_reg;

endmodule

// File: tb/tb_accum_cmd_sched.sv
// Bench for accum_cmd_sched: directed scenarios with fixed expectations plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_accum_cmd_sched;

  localparam int NUM_REQ   = 4;
  localparam int DRAIN_TMO = 8;
  localparam int M_RUN     = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_HALTED  = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_vld = '0;
  logic [NUM_REQ-1:0]   req_tgt = '0;
  logic [NUM_REQ*3-1:0] req_op = '0;
  logic [NUM_REQ-1:0]   req_rdy;
  logic [1:0]           cmd_vld;
  logic [5:0]           opcode;
  logic                 halt = 1'b0;
  logic                 sched_halted;
  logic                 drain_err;
  logic [31:0]          issue_cnt;

  accum_cmd_sched #(
    .NUM_REQ  (NUM_REQ),
    .DRAIN_TMO(DRAIN_TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_vld     (req_vld),
    .req_tgt     (req_tgt),
    .req_op      (req_op),
    .req_rdy     (req_rdy),
    .cmd_vld     (cmd_vld),
    .opcode      (opcode),
    .halt        (halt),
    .sched_halted(sched_halted),
    .drain_err   (drain_err),
    .issue_cnt   (issue_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int         m_state;
  int         m_age;
  int         m_ptr [2];
  int         m_cnt [2];
  int         m_gnt [2];
  logic       m_vld [2];
  logic [2:0] m_op  [2];
  logic       m_err;

  task automatic model_reset();
    m_state = M_RUN;
    m_age   = 0;
    m_err   = 1'b0;
    for (int a = 0; a < 2; a++) begin
      m_ptr[a] = 0;
      m_cnt[a] = 0;
      m_gnt[a] = -1;
      m_vld[a] = 1'b0;
      m_op[a]  = 3'b000;
    end
  endtask

  // Who gets accepted this cycle given current inputs and model state.
  function automatic logic [NUM_REQ-1:0] model_rdy();
    logic [NUM_REQ-1:0] rdy;
    rdy = '0;
    for (int a = 0; a < 2; a++) m_gnt[a] = -1;
    if (reset || m_state != M_RUN) return rdy;
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int r;
        r = (m_ptr[a] + k) % NUM_REQ;
        if (m_gnt[a] < 0 && req_vld[r] && int'(req_tgt[r]) == a) begin
          m_gnt[a] = r;
          rdy[r]   = 1'b1;
        end
      end
    end
    return rdy;
  endfunction

  // Advance the model across one rising edge (call after model_rdy).
  task automatic model_clock();
    logic halt_seen;
    halt_seen = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    for (int a = 0; a < 2; a++) begin
      if (m_gnt[a] >= 0) begin
        m_vld[a] = 1'b1;
        m_op[a]  = req_op[m_gnt[a]*3 +: 3];
        m_cnt[a] = (m_cnt[a] + 1) % 65536;
        m_ptr[a] = (m_gnt[a] + 1) % NUM_REQ;
        if (m_op[a] == 3'b111) halt_seen = 1'b1;
      end else begin
        m_vld[a] = 1'b0;
      end
    end
    if (m_state == M_RUN) begin
      if (halt_seen) begin
        m_state = M_DRAIN;
        m_age   = 0;
      end
    end else if (m_state == M_DRAIN) begin
      if (halt) begin
        m_state = M_HALTED;
      end else if (m_age == DRAIN_TMO - 1) begin
        m_state = M_HALTED;
        m_err   = 1'b1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req_vld = '0;
    req_tgt = '0;
    req_op  = '0;
    halt    = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    req_vld = '1;
    req_tgt = '0;
    req_op  = {4{3'b001}};
    #1;
    total++;
    if (req_rdy !== 4'b0000) begin
      bad++;
      $display("FAIL reset_rdy: got %b want 0000", req_rdy);
    end
    @(posedge clk); #1;
    total++;
    if ({cmd_vld, opcode} !== 8'h00) begin
      bad++;
      $display("FAIL reset_cmd: got vld=%b op=%b want 00/000000", cmd_vld, opcode);
    end
    total++;
    if ({issue_cnt, drain_err, sched_halted} !== 34'd0) begin
      bad++;
      $display("FAIL reset_status: got cnt=%h err=%b halted=%b want 0", issue_cnt, drain_err, sched_halted);
    end
    $display("[reset] cmd_vld=%b opcode=%b issue_cnt=%h", cmd_vld, opcode, issue_cnt);
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] want;
    do_reset();
    req_vld = 4'b1111;
    req_tgt = 4'b0000;
    req_op  = {4{3'b001}};
    for (int c = 0; c < 5; c++) begin
      #1;
      want = 4'b0001 << (c % 4);
      total++;
      if (req_rdy !== want) begin
        bad++;
        $display("FAIL rr_grant cycle %0d: got %b want %b", c, req_rdy, want);
      end
      @(posedge clk); #1;
      total++;
      if (cmd_vld !== 2'b01) begin
        bad++;
        $display("FAIL rr_cmd_vld cycle %0d: got %b want 01", c, cmd_vld);
      end
      $display("[rr] cycle %0d rdy=%b cmd_vld=%b cnt0=%0d", c, want, cmd_vld, issue_cnt[15:0]);
    end
    total++;
    if (issue_cnt !== {16'd0, 16'd5} || opcode[2:0] !== 3'b001) begin
      bad++;
      $display("FAIL rr_count: got cnt=%h op0=%b want 00000005/001", issue_cnt, opcode[2:0]);
    end
    req_vld = '0;
  endtask

  task automatic test_dual_target();
    do_reset();
    req_vld = 4'b0011;
    req_tgt = 4'b0010;
    req_op  = {3'b000, 3'b000, 3'b010, 3'b001};
    #1;
    total++;
    if (req_rdy !== 4'b0011) begin
      bad++;
      $display("FAIL dual_rdy: got %b want 0011", req_rdy);
    end
    @(posedge clk); #1;
    req_vld = '0;
    total++;
    if (cmd_vld !== 2'b11 || opcode !== {3'b010, 3'b001}) begin
      bad++;
      $display("FAIL dual_issue: got vld=%b op=%b want 11/010001", cmd_vld, opcode);
    end
    $display("[dual] cmd_vld=%b opcode=%b", cmd_vld, opcode);
    @(posedge clk); #1;
    total++;
    if (cmd_vld !== 2'b00 || opcode !== {3'b010, 3'b001}) begin
      bad++;
      $display("FAIL dual_hold: got vld=%b op=%b want 00/010001", cmd_vld, opcode);
    end
  endtask

  task automatic test_halt_ok();
    do_reset();
    req_vld = 4'b0100;
    req_tgt = 4'b0100;
    req_op  = {3'b000, 3'b111, 3'b000, 3'b000};
    #1;
    total++;
    if (req_rdy !== 4'b0100) begin
      bad++;
      $display("FAIL halt_accept: got %b want 0100", req_rdy);
    end
    @(posedge clk); #1;
    req_vld = 4'b1011;
    req_tgt = 4'b0000;
    req_op  = {4{3'b001}};
    total++;
    if (cmd_vld !== 2'b10 || opcode[5:3] !== 3'b111) begin
      bad++;
      $display("FAIL halt_issue: got vld=%b op1=%b want 10/111", cmd_vld, opcode[5:3]);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (req_rdy !== 4'b0000) begin
        bad++;
        $display("FAIL halt_drain_rdy %0d: got %b want 0000", i, req_rdy);
      end
      @(posedge clk); #1;
      total++;
      if (cmd_vld !== 2'b00 || sched_halted !== 1'b0) begin
        bad++;
        $display("FAIL halt_drain_state %0d: got vld=%b halted=%b want 00/0", i, cmd_vld, sched_halted);
      end
    end
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    total++;
    if (sched_halted !== 1'b1 || drain_err !== 1'b0) begin
      bad++;
      $display("FAIL halt_done: got halted=%b err=%b want 1/0", sched_halted, drain_err);
    end
    $display("[halt] halted=%b drain_err=%b", sched_halted, drain_err);
    @(posedge clk); #1;
    total++;
    if (req_rdy !== 4'b0000 || cmd_vld !== 2'b00 || sched_halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_sticky: got rdy=%b vld=%b halted=%b want 0000/00/1", req_rdy, cmd_vld, sched_halted);
    end
    req_vld = '0;
  endtask

  task automatic test_drain_timeout();
    do_reset();
    req_vld = 4'b0001;
    req_tgt = 4'b0000;
    req_op  = {3'b000, 3'b000, 3'b000, 3'b111};
    #1;
    total++;
    if (req_rdy !== 4'b0001) begin
      bad++;
      $display("FAIL tmo_accept: got %b want 0001", req_rdy);
    end
    @(posedge clk); #1;
    req_vld = '0;
    for (int k = 1; k <= DRAIN_TMO; k++) begin
      @(posedge clk); #1;
      total++;
      if (cmd_vld !== 2'b00 || sched_halted !== (k == DRAIN_TMO) || drain_err !== (k == DRAIN_TMO)) begin
        bad++;
        $display("FAIL tmo_cycle %0d: got vld=%b halted=%b err=%b want 00/%0d/%0d",
                 k, cmd_vld, sched_halted, drain_err, k == DRAIN_TMO, k == DRAIN_TMO);
      end
    end
    $display("[timeout] halted=%b drain_err=%b cnt0=%0d", sched_halted, drain_err, issue_cnt[15:0]);
    req_vld = 4'b1111;
    req_op  = {4{3'b001}};
    #1;
    total++;
    if (req_rdy !== 4'b0000 || issue_cnt !== 32'd1) begin
      bad++;
      $display("FAIL tmo_halted: got rdy=%b cnt=%h want 0000/00000001", req_rdy, issue_cnt);
    end
    @(posedge clk); #1;
    total++;
    if (cmd_vld !== 2'b00 || drain_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: got vld=%b err=%b want 00/1", cmd_vld, drain_err);
    end
    req_vld = '0;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    req_vld = 4'b0001;
    req_tgt = 4'b0010;
    req_op  = {3'b000, 3'b000, 3'b001, 3'b111};
    #1;
    total++;
    if (req_rdy !== 4'b0001) begin
      bad++;
      $display("FAIL rid_accept: got %b want 0001", req_rdy);
    end
    @(posedge clk); #1;
    req_vld = 4'b0010;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    total++;
    if (req_rdy !== 4'b0000) begin
      bad++;
      $display("FAIL rid_rdy_in_reset: got %b want 0000", req_rdy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (sched_halted !== 1'b0 || drain_err !== 1'b0 || issue_cnt !== 32'd0 || cmd_vld !== 2'b00) begin
      bad++;
      $display("FAIL rid_after_reset: got halted=%b err=%b cnt=%h vld=%b want 0/0/0/00",
               sched_halted, drain_err, issue_cnt, cmd_vld);
    end
    #1;
    total++;
    if (req_rdy !== 4'b0010) begin
      bad++;
      $display("FAIL rid_pending_rdy: got %b want 0010", req_rdy);
    end
    @(posedge clk); #1;
    req_vld = '0;
    total++;
    if (cmd_vld !== 2'b10 || opcode[5:3] !== 3'b001 || issue_cnt !== {16'd1, 16'd0}) begin
      bad++;
      $display("FAIL rid_pending_issue: got vld=%b op1=%b cnt=%h want 10/001/00010000",
               cmd_vld, opcode[5:3], issue_cnt);
    end
    $display("[reset_in_drain] cmd_vld=%b cnt=%h", cmd_vld, issue_cnt);
  endtask

  task automatic test_wrap();
    do_reset();
    req_vld = 4'b1000;
    req_tgt = 4'b1000;
    req_op  = {3'b010, 3'b000, 3'b000, 3'b000};
    repeat (65535) @(posedge clk);
    #1;
    total++;
    if (issue_cnt !== {16'hFFFF, 16'h0000}) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffff0000", issue_cnt);
    end
    @(posedge clk); #1;
    req_vld = '0;
    total++;
    if (issue_cnt !== 32'd0 || cmd_vld !== 2'b10 || sched_halted !== 1'b0 || drain_err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_rollover: got cnt=%h vld=%b halted=%b err=%b want 0/10/0/0",
               issue_cnt, cmd_vld, sched_halted, drain_err);
    end
    $display("[wrap] issue_cnt=%h cmd_vld=%b", issue_cnt, cmd_vld);
  endtask

  function automatic logic [2:0] rand_op();
    int v;
    v = $urandom_range(0, 15);
    if (v < 5) return 3'b001;
    if (v < 9) return 3'b010;
    if (v < 12) return 3'b100;
    if (v == 12) return 3'b111;
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [NUM_REQ-1:0] exp_rdy;
    logic [31:0]        exp_cnt;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (m_state == M_HALTED) reset = ($urandom_range(0, 3) == 0);
      else reset = ($urandom_range(0, 49) == 0);
      req_vld = 4'($urandom_range(0, 15));
      req_tgt = 4'($urandom_range(0, 15));
      for (int r = 0; r < NUM_REQ; r++) req_op[r*3 +: 3] = rand_op();
      halt = ($urandom_range(0, 3) == 0);
      #1;
      exp_rdy = model_rdy();
      total++;
      if (req_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL rnd_rdy cycle %0d: got %b want %b", c, req_rdy, exp_rdy);
      end
      model_clock();
      @(posedge clk); #1;
      exp_cnt = {16'(m_cnt[1]), 16'(m_cnt[0])};
      total++;
      if (cmd_vld !== {m_vld[1], m_vld[0]} || opcode !== {m_op[1], m_op[0]}) begin
        bad++;
        $display("FAIL rnd_cmd cycle %0d: got vld=%b op=%b want %b/%b",
                 c, cmd_vld, opcode, {m_vld[1], m_vld[0]}, {m_op[1], m_op[0]});
      end
      total++;
      if (issue_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL rnd_cnt cycle %0d: got %h want %h", c, issue_cnt, exp_cnt);
      end
      total++;
      if (sched_halted !== (m_state == M_HALTED) || drain_err !== m_err) begin
        bad++;
        $display("FAIL rnd_status cycle %0d: got halted=%b err=%b want %0d/%b",
                 c, sched_halted, drain_err, m_state == M_HALTED, m_err);
      end
      $display("[rnd] cycle %0d rst=%b vld=%b tgt=%b rdy=%b cmd_vld=%b state=%0d",
               c, reset, req_vld, req_tgt, exp_rdy, cmd_vld, m_state);
    end
    reset   = 1'b0;
    halt    = 1'b0;
    req_vld = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_dual_target();
    test_halt_ok();
    test_drain_timeout();
    test_reset_in_drain();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
